// File: rtl/mips_intc_pkg.sv
// Shared constants for the MIPS external interrupt controller.
// Optional input debounce is enabled with MIPS_INTC_DEBOUNCE_EN.
package mips_intc_pkg;
  localparam int NUM_SRC         = 6;
  localparam int TIMER_BIT       = 5;
  localparam int DEBOUNCE_CYCLES = 4;

  localparam logic [1:0] INTC_PENDING = 2'd0;
  localparam logic [1:0] INTC_MASK    = 2'd1;
  localparam logic [1:0] INTC_MODE    = 2'd2;
  localparam logic [1:0] INTC_RAW     = 2'd3;

  localparam logic [NUM_SRC-1:0] INTC_MASK_RST = 6'h3F;

  typedef enum logic {
    IntModeLevel = 1'b0,
    IntModeEdge  = 1'b1
  } int_mode_e;
endpackage

// File: rtl/mips_intc_if.sv
// Single-cycle-ack register bus between the data-memory side and the interrupt controller.
interface mips_intc_if;
  logic        req;
  logic        we;
  logic [1:0]  addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        ack;

  modport master (output req, we, addr, wdata, input rdata, ack);
  modport slave  (input req, we, addr, wdata, output rdata, ack);
endinterface

// File: rtl/mips_intc_sync.sv
// Two-flop synchroniser for one interrupt pin, with an optional stable-count
// debounce filter after it (MIPS_INTC_DEBOUNCE_EN).
module mips_intc_sync
  import mips_intc_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic async_i,
  output logic raw_o,
  output logic filt_o
);

  logic s1_q, s2_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
    end else begin
      s1_q <= async_i;
      s2_q <= s1_q;
    end
  end

  assign raw_o = s2_q;

`ifdef MIPS_INTC_DEBOUNCE_EN
  localparam int CW = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam logic [CW-1:0] CNT_LOAD = CW'(DEBOUNCE_CYCLES);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          filt_q, filt_d;

  // Down-counter reloads whenever s2 agrees with the filtered value.
  always_comb begin
    filt_d = filt_q;
    cnt_d  = CNT_LOAD;
    if (s2_q != filt_q) begin
      if (cnt_q == CW'(1)) filt_d = s2_q;
      else                 cnt_d  = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q  <= CNT_LOAD;
      filt_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      filt_q <= filt_d;
    end
  end

  assign filt_o = filt_q;
`else
  assign filt_o = s2_q;
`endif

endmodule

// File: rtl/mips_intc.sv
// MIPS hardware-interrupt front end: synchronised, latched, maskable 6-bit vector to CP0.
// Build with MIPS_INTC_DEBOUNCE_EN to insert a debounce filter on every pin.
//
// state    | meaning
// ST_IDLE  | waiting for a bus request; access performed on the request edge
// ST_ACK   | bus_ack high for this one cycle, requests ignored
module mips_intc
  import mips_intc_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_SRC-1:0] ext_int_i,
  input  logic               timer_int_i,
  mips_intc_if.slave         bus,
  output logic [NUM_SRC-1:0] int_o
);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_ACK  = 1'b1;

  logic [NUM_SRC-1:0] raw, filt;
  logic [NUM_SRC-1:0] filt_prev_q;
  logic [NUM_SRC-1:0] pending_q, pending_d;
  logic [NUM_SRC-1:0] mask_q, mask_d;
  logic [NUM_SRC-1:0] mode_q, mode_d;
  logic [NUM_SRC-1:0] int_q, int_d;
  logic [NUM_SRC-1:0] w1c, rd_sel;
  logic [0:0]         state_q, state_d;
  logic [31:0]        rdata_q, rdata_d;
  logic [31:NUM_SRC]  unused_wdata;

  assign unused_wdata = bus.wdata[31:NUM_SRC];

  for (genvar i = 0; i < NUM_SRC; i++) begin : g_sync
    mips_intc_sync u_sync (
      .clk     (clk),
      .rst     (rst),
      .async_i (ext_int_i[i]),
      .raw_o   (raw[i]),
      .filt_o  (filt[i])
    );
  end

  always_comb begin
    state_d = state_q;
    rdata_d = rdata_q;
    mask_d  = mask_q;
    mode_d  = mode_q;
    w1c     = '0;
    rd_sel  = '0;

    case (bus.addr)
      INTC_PENDING: rd_sel = pending_q;
      INTC_MASK:    rd_sel = mask_q;
      INTC_MODE:    rd_sel = mode_q;
      default:      rd_sel = raw;
    endcase

    if (state_q == ST_IDLE) begin
      if (bus.req) begin
        state_d = ST_ACK;
        rdata_d = {{(32-NUM_SRC){1'b0}}, rd_sel};
        if (bus.we) begin
          case (bus.addr)
            INTC_PENDING: w1c    = bus.wdata[NUM_SRC-1:0];
            INTC_MASK:    mask_d = bus.wdata[NUM_SRC-1:0];
            INTC_MODE:    mode_d = bus.wdata[NUM_SRC-1:0];
            default:      ;
          endcase
        end
      end
    end else begin
      state_d = ST_IDLE;
    end

    // Edge sources: a set event beats a same-cycle W1C.
    for (int i = 0; i < NUM_SRC; i++) begin
      if (mode_q[i] == IntModeEdge)
        pending_d[i] = (filt[i] & ~filt_prev_q[i]) | (pending_q[i] & ~w1c[i]);
      else
        pending_d[i] = filt[i];
    end
    pending_d = pending_d & ~(mode_d ^ mode_q);

    int_d            = pending_q & mask_q;
    int_d[TIMER_BIT] = int_d[TIMER_BIT] | timer_int_i;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      rdata_q     <= '0;
      mask_q      <= INTC_MASK_RST;
      mode_q      <= '0;
      pending_q   <= '0;
      filt_prev_q <= '0;
      int_q       <= '0;
    end else begin
      state_q     <= state_d;
      rdata_q     <= rdata_d;
      mask_q      <= mask_d;
      mode_q      <= mode_d;
      pending_q   <= pending_d;
      filt_prev_q <= filt;
      int_q       <= int_d;
    end
  end

  assign bus.ack   = (state_q == ST_ACK);
  assign bus.rdata = rdata_q;
  assign int_o     = int_q;

endmodule
